// File: rtl/dca_matrix_row_loader.sv
// Matrix row loader: turns a load command into one sLX read per row
// and streams the returned rows to the MAC through a credited FIFO.
module dca_matrix_row_loader #(
  parameter int BW_ADDR    = 32,
  parameter int BW_DATA    = 128,
  parameter int BW_NUM_ROW = 8,
  parameter int BW_STRIDE  = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rstnn,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [BW_ADDR-1:0]      cmd_addr,
  input  logic [BW_NUM_ROW-1:0]   cmd_num_row,
  input  logic [BW_STRIDE-1:0]    cmd_stride,
  output logic                    slxqvalid,
  input  logic [1:0]              slxqdready,
  output logic                    slxqlast,
  output logic                    slxqwrite,
  output logic [7:0]              slxqlen,
  output logic [2:0]              slxqsize,
  output logic [1:0]              slxqburst,
  output logic [BW_DATA/8-1:0]    slxqwstrb,
  output logic [BW_DATA-1:0]      slxqwdata,
  output logic [BW_ADDR-1:0]      slxqaddr,
  input  logic                    slxyvalid,
  input  logic                    slxylast,
  input  logic                    slxywreply,
  input  logic [1:0]              slxyresp,
  input  logic [BW_DATA-1:0]      slxyrdata,
  output logic [1:0]              slxydready,
  output logic                    row_valid,
  input  logic                    row_ready,
  output logic [BW_DATA-1:0]      row_data,
  output logic                    row_last,
  output logic                    busy,
  output logic                    done,
  output logic                    error
);

  localparam int BW_STRB = BW_DATA / 8;
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]            state;
  logic [1:0]            state_n;
  logic [BW_ADDR-1:0]    addr_q;
  logic [BW_NUM_ROW-1:0] num_row_q;
  logic [BW_STRIDE-1:0]  stride_q;
  logic [BW_NUM_ROW-1:0] issue_cnt;
  logic [BW_NUM_ROW-1:0] pop_cnt;
  logic [BW_NUM_ROW-1:0] last_idx;
  logic [CW-1:0]         outstanding;
  logic [CW-1:0]         fifo_cnt;
  logic [CW-1:0]         credit;
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [BW_DATA-1:0]    mem [FIFO_DEPTH];
  logic                  error_q;

  logic cmd_fire;
  logic req_fire;
  logic rsp_fire;
  logic pop_fire;
  logic in_xfer;
  logic unused_in;

  assign unused_in = &{1'b0, slxqdready[1],
                       slxylast, slxywreply};

  assign slxqlast  = 1'b1;
  assign slxqwrite = 1'b0;
  assign slxqlen   = 8'd0;
  assign slxqsize  = 3'($clog2(BW_STRB));
  assign slxqburst = 2'b01;
  assign slxqwstrb = '0;
  assign slxqwdata = '0;
  assign slxqaddr  = addr_q;

  // Reads in flight plus buffered rows never exceed the FIFO depth.
  assign credit = CW'(FIFO_DEPTH) - outstanding - fifo_cnt;

  assign cmd_ready  = (state == S_IDLE);
  assign in_xfer    = (state == S_ISSUE) || (state == S_DRAIN);
  assign slxqvalid  = (state == S_ISSUE) && (credit != '0);
  assign slxydready = {2{in_xfer}};

  assign cmd_fire = cmd_valid & cmd_ready;
  assign req_fire = slxqvalid & slxqdready[0];
  assign rsp_fire = slxyvalid & in_xfer;
  assign pop_fire = row_valid & row_ready;

  assign last_idx  = num_row_q - BW_NUM_ROW'(1);
  assign row_valid = (fifo_cnt != '0);
  assign row_data  = mem[rd_ptr];
  assign row_last  = row_valid && (pop_cnt == last_idx);

  assign busy  = (state != S_IDLE);
  assign done  = (state == S_DONE);
  assign error = error_q;

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE: begin
        if (cmd_fire) begin
          state_n = (cmd_num_row == '0) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (req_fire && issue_cnt == last_idx) begin
          state_n = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Leave on the final pop so done follows it by one cycle.
        if ((pop_fire && pop_cnt == last_idx) ||
            pop_cnt == num_row_q) begin
          state_n = S_DONE;
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstnn) begin
      state       <= S_IDLE;
      addr_q      <= '0;
      num_row_q   <= '0;
      stride_q    <= '0;
      issue_cnt   <= '0;
      pop_cnt     <= '0;
      outstanding <= '0;
      fifo_cnt    <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      error_q     <= 1'b0;
    end else begin
      state <= state_n;
      if (cmd_fire) begin
        addr_q    <= cmd_addr;
        num_row_q <= cmd_num_row;
        stride_q  <= cmd_stride;
        issue_cnt <= '0;
        pop_cnt   <= '0;
        error_q   <= 1'b0;
      end
      if (req_fire) begin
        issue_cnt <= issue_cnt + BW_NUM_ROW'(1);
        addr_q    <= addr_q + BW_ADDR'(stride_q);
      end
      if (rsp_fire && slxyresp != 2'b00) begin
        error_q <= 1'b1;
      end
      if (rsp_fire) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_fire) begin
        rd_ptr  <= rd_ptr + AW'(1);
        pop_cnt <= pop_cnt + BW_NUM_ROW'(1);
      end
      unique case ({req_fire, rsp_fire})
        2'b10:   outstanding <= outstanding + CW'(1);
        2'b01:   outstanding <= outstanding - CW'(1);
        default: outstanding <= outstanding;
      endcase
      unique case ({rsp_fire, pop_fire})
        2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rsp_fire) begin
      mem[wr_ptr] <= slxyrdata;
    end
  end

endmodule

// File: tb/tb_dca_matrix_row_loader.sv
// Bench for dca_matrix_row_loader: command table plus a reset
// sequence, with a scoreboard for request addresses and rows.
module tb_dca_matrix_row_loader;

  localparam int BW_ADDR    = 32;
  localparam int BW_DATA    = 128;
  localparam int BW_NUM_ROW = 8;
  localparam int BW_STRIDE  = 32;
  localparam int FIFO_DEPTH = 4;

  logic                 clk;
  logic                 rstnn;
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [31:0]          cmd_addr;
  logic [7:0]           cmd_num_row;
  logic [31:0]          cmd_stride;
  logic                 slxqvalid;
  logic [1:0]           slxqdready;
  logic                 slxqlast;
  logic                 slxqwrite;
  logic [7:0]           slxqlen;
  logic [2:0]           slxqsize;
  logic [1:0]           slxqburst;
  logic [15:0]          slxqwstrb;
  logic [127:0]         slxqwdata;
  logic [31:0]          slxqaddr;
  logic                 slxyvalid;
  logic                 slxylast;
  logic                 slxywreply;
  logic [1:0]           slxyresp;
  logic [127:0]         slxyrdata;
  logic [1:0]           slxydready;
  logic                 row_valid;
  logic                 row_ready;
  logic [127:0]         row_data;
  logic                 row_last;
  logic                 busy;
  logic                 done;
  logic                 error;

  dca_matrix_row_loader #(
    .BW_ADDR(BW_ADDR), .BW_DATA(BW_DATA),
    .BW_NUM_ROW(BW_NUM_ROW), .BW_STRIDE(BW_STRIDE),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rstnn(rstnn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_num_row(cmd_num_row),
    .cmd_stride(cmd_stride),
    .slxqvalid(slxqvalid), .slxqdready(slxqdready),
    .slxqlast(slxqlast), .slxqwrite(slxqwrite),
    .slxqlen(slxqlen), .slxqsize(slxqsize),
    .slxqburst(slxqburst), .slxqwstrb(slxqwstrb),
    .slxqwdata(slxqwdata), .slxqaddr(slxqaddr),
    .slxyvalid(slxyvalid), .slxylast(slxylast),
    .slxywreply(slxywreply), .slxyresp(slxyresp),
    .slxyrdata(slxyrdata), .slxydready(slxydready),
    .row_valid(row_valid), .row_ready(row_ready),
    .row_data(row_data), .row_last(row_last),
    .busy(busy), .done(done), .error(error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          n;
    logic [31:0] stride;
    int          bp;
    int          mode;
    int          err_idx;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    int          due;
    logic [1:0]  resp;
  } rsp_t;

  typedef struct {
    logic [127:0] data;
    logic         last;
  } row_t;

  vec_t        vecs [6];
  rsp_t        rsp_q [$];
  logic [31:0] exp_addr_q [$];
  row_t        exp_row_q [$];

  int total, bad, cyc_n, lat;
  int req_idx, err_idx, issued, pops;
  int done_cnt, first_q_cyc, done_cyc;
  int last_pop_cyc, fire_cyc, busy_bad;
  logic want_cmd, want_rst, req_rdy_r, rr_r, cmd_fired;

  function automatic logic [127:0] row_of(logic [31:0] a);
    return {a, ~a, a ^ 32'h1234_5678, a + 32'h0F0F_0F0F};
  endfunction

  task automatic chk(string nm, logic [127:0] act,
                     logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic miss(string nm);
    total++;
    bad++;
    $display("FAIL %s: got event want none", nm);
  endtask

  task automatic cyc();
    row_t r;
    @(negedge clk);
    rstnn      = !want_rst;
    cmd_valid  = want_cmd;
    slxqdready = {1'b0, req_rdy_r};
    row_ready  = rr_r;
    if (rsp_q.size() > 0 && rsp_q[0].due <= cyc_n) begin
      slxyvalid = 1'b1;
      slxyrdata = row_of(rsp_q[0].addr);
      slxyresp  = rsp_q[0].resp;
    end else begin
      slxyvalid = 1'b0;
      slxyrdata = '0;
      slxyresp  = 2'b00;
    end
    #1;
    if (rstnn) begin
      if (cmd_valid && cmd_ready) begin
        cmd_fired = 1'b1;
        fire_cyc  = cyc_n;
      end
      if (slxqvalid && first_q_cyc < 0) first_q_cyc = cyc_n;
      if (slxqvalid && slxqdready[0]) begin
        if (exp_addr_q.size() == 0) miss("req_extra");
        else chk("req_addr", slxqaddr, exp_addr_q.pop_front());
        rsp_q.push_back('{slxqaddr, cyc_n + lat,
                         (req_idx == err_idx) ? 2'd2 : 2'd0});
        req_idx++;
        issued++;
      end
      if (slxyvalid && slxydready[0]) void'(rsp_q.pop_front());
      if (row_valid && row_ready) begin
        if (exp_row_q.size() == 0) miss("row_extra");
        else begin
          r = exp_row_q.pop_front();
          chk("row_data", row_data, r.data);
          chk("row_last", row_last, r.last);
        end
        pops++;
        last_pop_cyc = cyc_n;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc_n;
      end
    end
    cyc_n++;
  endtask

  task automatic drive_rand(vec_t v, int rel);
    req_rdy_r = (v.mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
    rr_r      = (v.mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
    if (v.bp > 0 && rel <= v.bp) rr_r = 1'b0;
  endtask

  task automatic setup_cmd(vec_t v);
    logic [31:0] a;
    err_idx = v.err_idx;
    req_idx = 0; issued = 0; pops = 0; done_cnt = 0;
    first_q_cyc = -1; done_cyc = -1; last_pop_cyc = -1;
    busy_bad = 0; cmd_fired = 1'b0;
    cmd_addr = v.addr;
    cmd_num_row = 8'(v.n);
    cmd_stride = v.stride;
    for (int i = 0; i < v.n; i++) begin
      a = v.addr + 32'(i) * v.stride;
      exp_addr_q.push_back(a);
      exp_row_q.push_back('{row_of(a), i == v.n - 1});
    end
  endtask

  task automatic send_cmd(vec_t v);
    int bud;
    bud = 0;
    want_cmd = 1'b1;
    while (!cmd_fired && bud < 20) begin
      drive_rand(v, 0);
      cyc();
      bud++;
    end
    want_cmd = 1'b0;
  endtask

  task automatic run_cmd(vec_t v);
    int bud, rel;
    setup_cmd(v);
    send_cmd(v);
    if (!cmd_fired) begin
      miss("cmd_accept_timeout");
      return;
    end
    drive_rand(v, 1);
    cyc();
    chk("err_clear", error, 1'b0);
    chk("busy_start", busy, 1'b1);
    bud = 0;
    while (done_cnt == 0 && bud < 400) begin
      rel = cyc_n - fire_cyc;
      drive_rand(v, rel);
      cyc();
      if (!busy && done_cnt == 0) busy_bad++;
      if (v.bp > 0 && rel == v.bp) begin
        chk("bp_issued", issued, FIFO_DEPTH);
        chk("bp_qvalid", slxqvalid, 1'b0);
      end
      bud++;
    end
    if (done_cnt == 0) begin
      miss("done_timeout");
      return;
    end
    if (v.n == 0) begin
      chk("done_lat_zero", done_cyc, fire_cyc + 1);
      chk("zero_no_req", first_q_cyc, -1);
    end else begin
      chk("first_req_lat", first_q_cyc, fire_cyc + 1);
      chk("done_after_pop", done_cyc, last_pop_cyc + 1);
    end
    chk("issued", issued, v.n);
    chk("pops", pops, v.n);
    chk("busy_window", busy_bad, 0);
    chk("err_done", error, v.exp_err);
    chk("rows_left", exp_row_q.size(), 0);
    drive_rand(v, 999);
    cyc();
    chk("done_pulse", done, 1'b0);
    chk("busy_end", busy, 1'b0);
    chk("ready_end", cmd_ready, 1'b1);
    chk("err_sticky", error, v.exp_err);
  endtask

  task automatic check_reset_values(string tag);
    chk({tag, "_cmd_ready"}, cmd_ready, 1'b1);
    chk({tag, "_qvalid"}, slxqvalid, 1'b0);
    chk({tag, "_qaddr"}, slxqaddr, 32'h0);
    chk({tag, "_ydready"}, slxydready, 2'b00);
    chk({tag, "_row_valid"}, row_valid, 1'b0);
    chk({tag, "_row_last"}, row_last, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_error"}, error, 1'b0);
  endtask

  initial begin
    int bud;
    vec_t rv;
    total = 0; bad = 0; cyc_n = 0; lat = 2;
    want_cmd = 1'b0; want_rst = 1'b1;
    req_rdy_r = 1'b1; rr_r = 1'b1;
    cmd_fired = 1'b0; err_idx = -1;
    req_idx = 0; issued = 0; pops = 0;
    rstnn = 1'b0; cmd_valid = 1'b0;
    cmd_addr = '0; cmd_num_row = '0; cmd_stride = '0;
    slxqdready = 2'b00; slxyvalid = 1'b0;
    slxylast = 1'b1; slxywreply = 1'b0;
    slxyresp = 2'b00; slxyrdata = '0; row_ready = 1'b0;

    vecs[0] = '{32'h0000_1000, 4, 32'h40, 0, 0, -1, 1'b0};
    vecs[1] = '{32'h0000_8000, 8, 32'h80, 20, 0, -1, 1'b0};
    vecs[2] = '{32'h0000_3000, 0, 32'h40, 0, 0, -1, 1'b0};
    vecs[3] = '{32'h0000_4000, 3, 32'h20, 0, 0, 1, 1'b1};
    vecs[4] = '{32'hFFFF_FFC0, 2, 32'h40, 0, 0, -1, 1'b0};
    vecs[5] = '{32'h0001_0000, 9, 32'h100, 0, 2, -1, 1'b0};

    for (int i = 0; i < 3; i++) cyc();
    want_rst = 1'b0;
    cyc();
    check_reset_values("rst");
    chk("qsize", slxqsize, 3'd4);
    chk("qlen", slxqlen, 8'd0);
    chk("qburst", slxqburst, 2'b01);
    chk("qlast_write", {slxqlast, slxqwrite}, 2'b10);

    for (int i = 0; i < 6; i++) run_cmd(vecs[i]);

    // Abandon a command with two reads in flight.
    lat = 6;
    rv = '{32'h0000_2000, 4, 32'h10, 0, 0, -1, 1'b0};
    setup_cmd(rv);
    send_cmd(rv);
    bud = 0;
    while (issued < 2 && bud < 20) begin
      cyc();
      bud++;
    end
    chk("mid_issued", issued, 2);
    want_rst = 1'b1;
    cyc();
    want_rst = 1'b0;
    cyc();
    check_reset_values("mid");
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (slxyvalid) chk("late_rsp_dready", slxydready, 2'b00);
    end
    rsp_q.delete();
    exp_addr_q.delete();
    exp_row_q.delete();
    lat = 2;
    run_cmd(vecs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
